// File: rtl/ai_core_pkg.sv
// Shared AI-core types: accumulator FSM state and saturation bound helpers.
package ai_core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } acc_state_e;

  // Bounds are returned in the low `width` bits of a 64-bit word; callers truncate.
  function automatic logic [63:0] sat_max(input int unsigned width, input bit is_signed);
    logic [63:0] ones;
    ones = '1;
    if (is_signed) begin
      sat_max = ones >> (65 - width);
    end else begin
      sat_max = ones >> (64 - width);
    end
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width, input bit is_signed);
    if (is_signed) begin
      sat_min = 64'd1 << (width - 1);
    end else begin
      sat_min = '0;
    end
  endfunction

endpackage

// File: rtl/acc_lane.sv
// Single accumulator lane: clear, enable, extend-and-add, optional saturation
// with sticky flag (saturation compiled in by ACCUMULATOR_N_SAT_EN).
module acc_lane
  import ai_core_pkg::*;
#(
  parameter int unsigned IN_SIZE   = 12,
  parameter int unsigned ACC_SIZE  = 24,
  parameter bit          IS_SIGNED = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [IN_SIZE-1:0]  in_i,
  output logic [ACC_SIZE-1:0] acc_o,
  output logic                sat_o
);

  localparam int unsigned AW = ACC_SIZE + 1;

  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic [AW-1:0]       ext_w, acc_w, sum_w;
  logic [ACC_SIZE-1:0] res;

  // One guard bit above ACC_SIZE exposes overflow of the lane addition.
  always_comb begin
    if (IS_SIGNED) begin
      ext_w = AW'($signed(in_i));
      acc_w = AW'($signed(acc_q));
    end else begin
      ext_w = AW'(in_i);
      acc_w = AW'(acc_q);
    end
    sum_w = acc_w + ext_w;
  end

`ifdef ACCUMULATOR_N_SAT_EN
  localparam logic [ACC_SIZE-1:0] SAT_MAX = ACC_SIZE'(sat_max(ACC_SIZE, IS_SIGNED));
  localparam logic [ACC_SIZE-1:0] SAT_MIN = ACC_SIZE'(sat_min(ACC_SIZE, IS_SIGNED));

  logic sat_q, sat_d;
  logic ovf;

  always_comb begin
    if (IS_SIGNED) begin
      ovf = sum_w[ACC_SIZE] ^ sum_w[ACC_SIZE-1];
      res = ovf ? (sum_w[ACC_SIZE] ? SAT_MIN : SAT_MAX) : sum_w[ACC_SIZE-1:0];
    end else begin
      ovf = sum_w[ACC_SIZE];
      res = ovf ? SAT_MAX : sum_w[ACC_SIZE-1:0];
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (clr_i) begin
      sat_d = 1'b0;
    end else if (en_i) begin
      sat_d = sat_q | ovf;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`else
  logic unused_carry;
  assign unused_carry = sum_w[ACC_SIZE];
  assign res          = sum_w[ACC_SIZE-1:0];
  assign sat_o        = 1'b0;
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = res;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/accumulator_n.sv
// Multi-lane beat accumulator with valid/ready in and out; FSM, beat counter
// and handshakes live here. Saturation selected by ACCUMULATOR_N_SAT_EN.
module accumulator_n
  import ai_core_pkg::*;
#(
  parameter int unsigned IN_NUM    = 2,
  parameter int unsigned IN_SIZE   = 12,
  parameter int unsigned ACC_SIZE  = 24,
  parameter bit          IS_SIGNED = 1'b1,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IN_SIZE-1:0]   in_i [0:IN_NUM-1],
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_SIZE-1:0]  out_o [0:IN_NUM-1],
  output logic [IN_NUM-1:0]    sat_o,
  output logic                 busy_o
);

  acc_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lane_clr, lane_en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter is never zero in ACC, so reaching 1 on a beat marks the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = len_i;
          state_d = (len_i == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (in_valid_i) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == ACC);
    out_valid_o = (state_q == DONE);
    busy_o      = (state_q != IDLE);
    lane_clr    = (state_q == IDLE) && start_i;
    lane_en     = (state_q == ACC) && in_valid_i;
  end

  for (genvar g = 0; g < IN_NUM; g++) begin : g_lane
    acc_lane #(
      .IN_SIZE  (IN_SIZE),
      .ACC_SIZE (ACC_SIZE),
      .IS_SIGNED(IS_SIGNED)
    ) u_lane (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .clr_i (lane_clr),
      .en_i  (lane_en),
      .in_i  (in_i[g]),
      .acc_o (out_o[g]),
      .sat_o (sat_o[g])
    );
  end

endmodule

// File: tb/tb_accumulator_n.sv
// Directed self-checking bench for accumulator_n (IN_NUM=2, IN_SIZE=12, ACC_SIZE=16).
module tb_accumulator_n;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  len_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [11:0] in_i [0:1];
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_o [0:1];
  logic [1:0]  sat_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  accumulator_n #(
    .IN_NUM   (2),
    .IN_SIZE  (12),
    .ACC_SIZE (16),
    .IS_SIGNED(1'b1),
    .CNT_WIDTH(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .len_i      (len_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_i       (in_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_o      (out_o),
    .sat_o      (sat_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic beat(input logic [11:0] l0, input logic [11:0] l1);
    in_valid_i = 1'b1;
    in_i[0]    = l0;
    in_i[1]    = l1;
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic start_job(input logic [7:0] len);
    start_i = 1'b1;
    len_i   = len;
    @(negedge clk);
    start_i = 1'b0;
    len_i   = 8'hAA;
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    len_i       = '0;
    in_valid_i  = 1'b0;
    in_i[0]     = '0;
    in_i[1]     = '0;
    out_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);

    check("rst_in_ready", 32'(in_ready_o), 32'd0);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_out0", 32'(out_o[0]), 32'd0);
    check("rst_out1", 32'(out_o[1]), 32'd0);
    check("rst_sat", 32'(sat_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Basic run
    start_job(8'd3);
    check("basic_in_ready", 32'(in_ready_o), 32'd1);
    check("basic_busy", 32'(busy_o), 32'd1);
    beat(12'd5, 12'd100);
    beat(-12'sd2, 12'd100);
    check("basic_no_early_valid", 32'(out_valid_o), 32'd0);
    beat(12'd7, 12'd100);
    check("basic_out_valid", 32'(out_valid_o), 32'd1);
    check("basic_in_ready_done", 32'(in_ready_o), 32'd0);
    check("basic_out0", 32'(out_o[0]), 32'd10);
    check("basic_out1", 32'(out_o[1]), 32'd300);
    check("basic_sat", 32'(sat_o), 32'd0);
    drain();
    check("basic_idle_busy", 32'(busy_o), 32'd0);
    check("basic_idle_valid", 32'(out_valid_o), 32'd0);

    // Input bubbles
    start_job(8'd4);
    for (int i = 0; i < 8; i++) begin
      if (i == 6) check("bubble_not_done", 32'(out_valid_o), 32'd0);
      in_valid_i = (i % 2 == 0);
      in_i[0]    = 12'd1;
      in_i[1]    = 12'd1;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    check("bubble_out_valid", 32'(out_valid_o), 32'd1);
    check("bubble_out0", 32'(out_o[0]), 32'd4);
    check("bubble_out1", 32'(out_o[1]), 32'd4);

    // Output backpressure with an ignored start pulse
    for (int i = 0; i < 5; i++) begin
      start_i = (i == 2);
      len_i   = 8'd0;
      check("bp_out_valid", 32'(out_valid_o), 32'd1);
      check("bp_in_ready", 32'(in_ready_o), 32'd0);
      check("bp_busy", 32'(busy_o), 32'd1);
      check("bp_out0", 32'(out_o[0]), 32'd4);
      @(negedge clk);
    end
    start_i = 1'b0;
    drain();
    check("bp_idle_busy", 32'(busy_o), 32'd0);
    check("bp_idle_valid", 32'(out_valid_o), 32'd0);
    check("bp_acc_kept", 32'(out_o[0]), 32'd4);
    @(negedge clk);
    check("bp_still_idle", 32'(busy_o), 32'd0);

    // Zero length
    start_job(8'd0);
    check("zero_out_valid", 32'(out_valid_o), 32'd1);
    check("zero_in_ready", 32'(in_ready_o), 32'd0);
    check("zero_out0", 32'(out_o[0]), 32'd0);
    check("zero_out1", 32'(out_o[1]), 32'd0);
    drain();

    // Overflow: 20 x 2047 = 40940
    start_job(8'd20);
    for (int i = 0; i < 20; i++) beat(12'd2047, 12'd0);
    check("ovf_out_valid", 32'(out_valid_o), 32'd1);
`ifdef ACCUMULATOR_N_SAT_EN
    check("ovf_out0", 32'(out_o[0]), 32'd32767);
    check("ovf_sat", 32'(sat_o), 32'd1);
`else
    check("ovf_out0", 32'(out_o[0]), 32'd40940);
    check("ovf_sat", 32'(sat_o), 32'd0);
`endif
    check("ovf_out1", 32'(out_o[1]), 32'd0);
    drain();

    // Reset mid-operation
    start_job(8'd5);
    beat(12'd3, 12'd3);
    beat(12'd3, 12'd3);
    rst_ni = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy_o), 32'd0);
    check("rstmid_in_ready", 32'(in_ready_o), 32'd0);
    check("rstmid_out_valid", 32'(out_valid_o), 32'd0);
    check("rstmid_out0", 32'(out_o[0]), 32'd0);
    check("rstmid_out1", 32'(out_o[1]), 32'd0);
    check("rstmid_sat", 32'(sat_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    start_job(8'd2);
    beat(12'd1, -12'sd1);
    beat(12'd2, -12'sd5);
    check("post_rst_valid", 32'(out_valid_o), 32'd1);
    check("post_rst_out0", 32'(out_o[0]), 32'd3);
    check("post_rst_out1", 32'(out_o[1]), 32'd65530);
    check("post_rst_sat", 32'(sat_o), 32'd0);
    drain();
    check("post_rst_idle", 32'(busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/accumulator_n.md
# accumulator_n

Multi-lane accumulator that sits directly downstream of the operand extender in the AI core datapath. It consumes IN_NUM already-widened lanes per beat over a valid/ready handshake and sums a programmed number of beats per lane into ACC_SIZE-bit accumulators. It then presents the per-lane totals on an output valid/ready handshake. It is the reduction stage between the widening stage and result write-back.

## Interface
- IN_NUM, 2, number of parallel lanes
- IN_SIZE, 12, width of each incoming (already extended) lane
- ACC_SIZE, 24, accumulator width per lane; must be >= IN_SIZE
- IS_SIGNED, 1, 1 = lanes are two's complement, 0 = unsigned
- CNT_WIDTH, 8, width of the beat-count field
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  launch a new accumulation; sampled only in IDLE
- len_i  in  CNT_WIDTH  number of beats to accumulate; sampled with start_i
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  block accepts input beat
- in_i  in  [IN_SIZE-1:0] x [0:IN_NUM-1]  lane operands
- out_valid_o  out  1  results valid
- out_ready_i  in  1  consumer accepts results
- out_o  out  [ACC_SIZE-1:0] x [0:IN_NUM-1]  per-lane totals
- sat_o  out  IN_NUM  per-lane saturation-occurred flags, valid with out_valid_o; tied to 0 when the saturation feature is compiled out
- busy_o  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE: in_ready_o=0, out_valid_o=0. On start_i=1:
  - clear all accumulators and sat flags;
  - load the beat counter with len_i;
  - go to ACC, or to DONE if len_i==0 (totals are 0).
- ACC: in_ready_o=1. On each beat with in_valid_i=1:
  - for every lane, acc[i] <= acc[i] + ext(in_i[i]), where ext sign-extends to ACC_SIZE when IS_SIGNED=1 and zero-extends otherwise;
  - decrement the counter;
  - on the beat that brings the counter to 0, go to DONE.
  - Cycles without in_valid_i change nothing.
- DONE: out_valid_o=1; out_o and sat_o are the registered accumulators and flags, and are held stable. On out_ready_i=1, go to IDLE.
- Arithmetic without saturation: modulo 2^ACC_SIZE (wrap).
- start_i outside IDLE is ignored. len_i is ignored except in the cycle it is sampled.
- Reset (any time, including mid-ACC or mid-DONE):
  - state=IDLE; accumulators, counter and sat flags cleared;
  - in_ready_o=0, out_valid_o=0, out_o=0, sat_o=0, busy_o=0.

## Timing
- in_ready_o and out_valid_o are decoded from registered state only, with no combinational path from in_valid_i or out_ready_i.
- start_i in cycle t puts the block in ACC (or DONE) at cycle t+1, so in_ready_o=1 from t+1.
- Last input handshake at cycle t gives out_valid_o=1 at cycle t+1 (one-cycle latency).
- An output handshake at cycle t returns the block to IDLE at t+1. start_i is accepted from t+1, so the minimum gap between jobs is one IDLE cycle.
- Throughput is one beat per cycle while in ACC.

## Configuration
- ACCUMULATOR_N_SAT_EN defined:
  - each lane addition saturates to the ACC_SIZE range: signed [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1], or unsigned [0, 2^ACC_SIZE-1];
  - the lane's sat_o bit sets sticky on the first clipping beat of the job.
- Undefined: additions wrap and sat_o is constant 0.

## Structure
- Shared package ai_core_pkg holds the FSM state enum (acc_state_e: IDLE, ACC, DONE) and the saturation min/max helper functions parameterised by width and signedness.
- One sub-module, acc_lane: a single-lane register with clear, enable, extend-and-add, optional saturation, and a sticky flag. It is instantiated IN_NUM times in a generate loop. The top level holds the FSM, the counter and the handshakes.

## Test plan
Configuration for all cases: IN_NUM=2, IN_SIZE=12, IS_SIGNED=1, ACC_SIZE=16.
- Basic run:
  - Stimulus: start_i with len_i=3; beats lane0 = 5, -2, 7 and lane1 = 100, 100, 100, with in_valid_i always high.
  - Response: out_valid_o one cycle after the third beat; out_o = {10, 300}; sat_o = 0.
- Input bubbles:
  - Stimulus: len_i=4, with in_valid_i toggling 1,0,1,0,... and all lanes = 1.
  - Response: only handshaken beats are counted; out_o = {4, 4} after the fourth valid beat.
- Output backpressure:
  - Stimulus: out_ready_i held low for 5 cycles in DONE.
  - Response: out_o stable, in_ready_o=0, busy_o=1, and a start_i pulse during this time is ignored. After out_ready_i=1 the block is in IDLE the next cycle.
- Zero length:
  - Stimulus: len_i=0.
  - Response: out_valid_o=1 in the cycle after start_i, with out_o = {0, 0} and no input handshake.
- Overflow:
  - Stimulus: lane0 = 2047 for 20 beats.
  - Response with ACCUMULATOR_N_SAT_EN: out_o[0] = 32767, sat_o[0] = 1.
  - Response without it: out_o[0] = -24596 (40940 wrapped), sat_o = 0.
- Reset mid-operation:
  - Stimulus: assert rst_ni=0 after 2 of 5 beats.
  - Response: all outputs are 0 immediately. A new job then produces correct totals with no residue from the aborted job.
